serial_word_tx: RTL and testbench

Parallel-to-serial front end for the "101" sequence detector. Accepts W-bit words over a valid/ready handshake and shifts them out MSB-first, one bit per clock, on a single serial line that drives the detector's `x` input directly. A qualifying `x_valid` strobe marks real data bits so downstream logic can ignore idle filler.

---
 rtl/serial_word_tx_pkg.sv | 26 ++
 rtl/serial_word_tx_shreg.sv | 34 +++
 rtl/serial_word_tx.sv | 146 ++++++++++++++
 tb/tb_serial_word_tx.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/serial_word_tx_pkg.sv
// rtl/serial_word_tx_pkg.sv - shared types and constants for the serial word transmitter
//
// Contents:
//   state_t           FSM states (ST_PAR is only reachable with SERIAL_WORD_TX_PARITY_EN)
//   IDLE_BIT_DEFAULT  level driven on x between words
//   W_MIN / W_MAX     legal word-width range
//   cnt_width()       bit-counter width for a given word width ($clog2(W), minimum 1)
package serial_word_tx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_PAR   = 2'd2
    } state_t;

    localparam logic IDLE_BIT_DEFAULT = 1'b0;

    localparam int W_MIN = 2;
    localparam int W_MAX = 32;

    // The counter runs W-1 down to 0, so $clog2(W) bits always hold W-1.
    function automatic int cnt_width(input int w);
        return (w < 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/serial_word_tx_shreg.sv
// rtl/serial_word_tx_shreg.sv - W-bit loadable left shift register with MSB tap
//
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset (clears the register)
//   load        capture din (has priority over shift)
//   shift       shift left by one, zero fill
//   din[W-1:0]  parallel load value
//   msb         current bit W-1
module serial_word_tx_shreg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         shift,
    input  logic [W-1:0] din,
    output logic         msb
);

    logic [W-1:0] q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (load) begin
            q <= din;
        end else if (shift) begin
            q <= {q[W-2:0], 1'b0};
        end
    end

    assign msb = q[W-1];

endmodule

// File: rtl/serial_word_tx.sv
// rtl/serial_word_tx.sv - parallel-to-serial word transmitter, MSB first, valid/ready input
//
// Build option: SERIAL_WORD_TX_PARITY_EN appends one even-parity bit after every word.
//
// Parameters:
//   W         word width, 2..32
//   IDLE_BIT  level on x when no bit is being sent
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   din[W-1:0]          word to send, sampled only on the accepting edge
//   din_valid           din holds a word
//   din_ready           word accepted on this edge if din_valid (state/counter only)
//   x                   registered serial data
//   x_valid             registered, high while x carries a data or parity bit
//   busy                registered, high while a word (or its parity bit) is on x
module serial_word_tx
    import serial_word_tx_pkg::*;
#(
    parameter int   W        = 8,
    parameter logic IDLE_BIT = IDLE_BIT_DEFAULT
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] din,
    input  logic         din_valid,
    output logic         din_ready,
    output logic         x,
    output logic         x_valid,
    output logic         busy
);

    localparam int CW = cnt_width(W);
    typedef logic [CW-1:0] cnt_t;
    localparam cnt_t CNT_LAST = cnt_t'(W - 1);

    state_t state_q, state_d;
    cnt_t   cnt_q, cnt_d;
    logic   x_d, x_valid_d, busy_d;
    logic   take, sr_load, sr_shift, sr_msb;

`ifdef SERIAL_WORD_TX_PARITY_EN
    logic   par_q, par_d;
`endif

    // The MSB goes straight into the x flop on the accepting edge, so the
    // shift register only holds the bits still to come; its MSB is always
    // the next bit to present.
    serial_word_tx_shreg #(.W(W)) u_shreg (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (sr_load),
        .shift (sr_shift),
        .din   ({din[W-2:0], 1'b0}),
        .msb   (sr_msb)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            x       <= IDLE_BIT;
            x_valid <= 1'b0;
            busy    <= 1'b0;
`ifdef SERIAL_WORD_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            x       <= x_d;
            x_valid <= x_valid_d;
            busy    <= busy_d;
`ifdef SERIAL_WORD_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        din_ready = 1'b0;
        take      = 1'b0;
        sr_load   = 1'b0;
        sr_shift  = 1'b0;
        x_d       = IDLE_BIT;
        x_valid_d = 1'b0;
        busy_d    = 1'b0;
`ifdef SERIAL_WORD_TX_PARITY_EN
        par_d     = par_q;
`endif

        case (state_q)
            ST_IDLE: begin
                din_ready = 1'b1;
            end
            ST_SHIFT: begin
                if (cnt_q != '0) begin
                    sr_shift  = 1'b1;
                    cnt_d     = cnt_q - cnt_t'(1);
                    x_d       = sr_msb;
                    x_valid_d = 1'b1;
                    busy_d    = 1'b1;
`ifdef SERIAL_WORD_TX_PARITY_EN
                    par_d     = par_q ^ sr_msb;
`endif
                end else begin
`ifdef SERIAL_WORD_TX_PARITY_EN
                    state_d   = ST_PAR;
                    x_d       = par_q;
                    x_valid_d = 1'b1;
                    busy_d    = 1'b1;
`else
                    din_ready = 1'b1;
                    state_d   = ST_IDLE;
`endif
                end
            end
`ifdef SERIAL_WORD_TX_PARITY_EN
            ST_PAR: begin
                din_ready = 1'b1;
                state_d   = ST_IDLE;
            end
`endif
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // An accepted word overrides whatever the state above chose, which
        // gives gapless back-to-back words from the last-bit/parity cycle.
        take = din_ready && din_valid;
        if (take) begin
            sr_load   = 1'b1;
            state_d   = ST_SHIFT;
            cnt_d     = CNT_LAST;
            x_d       = din[W-1];
            x_valid_d = 1'b1;
            busy_d    = 1'b1;
`ifdef SERIAL_WORD_TX_PARITY_EN
            par_d     = din[W-1];
`endif
        end
    end

endmodule

// File: tb/tb_serial_word_tx.sv
// tb/tb_serial_word_tx.sv - self-checking bench for serial_word_tx with a bit-queue reference model
module tb_serial_word_tx;

    localparam int W  = 8;
`ifdef SERIAL_WORD_TX_PARITY_EN
    localparam int P  = 1;
`else
    localparam int P  = 0;
`endif
    localparam int L3 = 3 + P;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [W-1:0] din;
    logic         din_valid;
    logic         din_ready, x, x_valid, busy;
    logic [2:0]   din3;
    logic         din3_valid;
    logic         din3_ready, x3, x3_valid, busy3;

    always #5 clk = ~clk;

    serial_word_tx #(.W(W)) u_dut (
        .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid),
        .din_ready(din_ready), .x(x), .x_valid(x_valid), .busy(busy)
    );

    serial_word_tx #(.W(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .din(din3), .din_valid(din3_valid),
        .din_ready(din3_ready), .x(x3), .x_valid(x3_valid), .busy(busy3)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the queue holds every bit still owed on x, head first.
    // The transmitter can take a word whenever at most one bit is still owed.
    bit rem[$];
    bit m_rdy;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem.delete();
        end else begin
            m_rdy = (rem.size() <= 1);
            if (rem.size() > 0) void'(rem.pop_front());
            if (m_rdy && din_valid) begin
                for (int i = W - 1; i >= 0; i--) rem.push_back(din[i]);
                if (P == 1) rem.push_back(^din);
            end
        end
    end

    logic [63:0] seen, seen3, rdy3;
    int seen_n, seen3_n, run, max_run, rdy_in_word;

    task automatic clear_obs();
        seen = '0; seen_n = 0; run = 0; max_run = 0; rdy_in_word = 0;
        seen3 = '0; rdy3 = '0; seen3_n = 0;
    endtask

    // One cycle: compare against the model on the falling edge, then record.
    task automatic step();
        logic ev, ex;
        @(negedge clk);
        ev = (rem.size() > 0);
        ex = ev ? rem[0] : 1'b0;
        chk("x", x, ex);
        chk("x_valid", x_valid, ev);
        chk("busy", busy, ev);
        chk("din_ready", din_ready, rem.size() <= 1);
        if (x_valid) begin
            seen = {seen[62:0], x};
            seen_n++;
            run++;
            if (run > max_run) max_run = run;
            if (din_ready) rdy_in_word++;
        end else begin
            run = 0;
        end
        if (x3_valid) begin
            seen3 = {seen3[62:0], x3};
            rdy3  = {rdy3[62:0], din3_ready};
            seen3_n++;
        end
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 60 && rem.size() != 0; k++) step();
        chk("idle_timeout", rem.size(), 0);
        step();
    endtask

    // Sends a, then b either held pending from the start or raised after gap cycles.
    task automatic send_pair(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                             input int gap, input logic [63:0] exp_bits);
        clear_obs();
        din = a; din_valid = 1'b1;
        step();
        if (gap > 0) begin
            din_valid = 1'b0; din = W'($urandom);
            repeat (gap) step();
        end
        din = b; din_valid = 1'b1;
        for (int k = 0; k < 40 && rem.size() > 1; k++) step();
        step();
        din_valid = 1'b0; din = W'($urandom);
        wait_idle();
        chk({name, "_count"}, seen_n, 2 * (W + P));
        chk({name, "_bits"}, seen, exp_bits);
        chk({name, "_run"}, max_run, 2 * (W + P));
        chk({name, "_ready_cycles"}, rdy_in_word, 2);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        din = '0; din_valid = 1'b0; din3 = '0; din3_valid = 1'b0;
        clear_obs();
        #12;
        chk("rst_x", x, 1'b0);
        chk("rst_x_valid", x_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_din_ready", din_ready, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;

        // Single word A5, then idle.
        clear_obs();
        din = 8'hA5; din_valid = 1'b1;
        step();
        din_valid = 1'b0; din = 8'h3C;
        wait_idle();
        chk("a5_count", seen_n, W + P);
        chk("a5_bits", seen, (P == 1) ? 64'h14A : 64'hA5);

        // Back-to-back FF then 00 with valid held high.
        send_pair("ff00", 8'hFF, 8'h00, 0, (P == 1) ? 64'h3FC00 : 64'hFF00);
        // Second word raised mid-word; din scrambled after the handshake.
        send_pair("mid", 8'h3C, 8'h5A, 2, (P == 1) ? 64'hF0B4 : 64'h3C5A);
`ifdef SERIAL_WORD_TX_PARITY_EN
        send_pair("par", 8'h07, 8'h03, 0, 64'h1E06);
`endif

        // Reset during the 4th bit of C3.
        clear_obs();
        din = 8'hC3; din_valid = 1'b1;
        step();
        din_valid = 1'b0;
        repeat (3) step();
        #2 rst_n = 1'b0;
        #1;
        chk("abort_x", x, 1'b0);
        chk("abort_x_valid", x_valid, 1'b0);
        chk("abort_busy", busy, 1'b0);
        chk("abort_prefix", seen, 64'hC);
        chk("abort_prefix_count", seen_n, 4);
        step();
        step();
        rst_n = 1'b1;
        clear_obs();
        din = 8'h81; din_valid = 1'b1;
        step();
        din_valid = 1'b0; din = 8'hFF;
        wait_idle();
        chk("after_rst_count", seen_n, W + P);
        chk("after_rst_bits", seen, (P == 1) ? 64'h102 : 64'h81);

        // W=3 instance: 101 three times back-to-back.
        clear_obs();
        din3 = 3'b101; din3_valid = 1'b1;
        repeat (2 * L3 + 1) step();
        din3_valid = 1'b0;
        repeat (8) step();
        chk("w3_count", seen3_n, 3 * L3);
        chk("w3_bits", seen3, (P == 1) ? 64'hAAA : 64'h16D);
        chk("w3_ready", rdy3, (P == 1) ? 64'h111 : 64'h49);

        // Randomised traffic against the model.
        clear_obs();
        repeat (400) begin
            din_valid = ($urandom_range(0, 3) != 0);
            din = W'($urandom);
            step();
        end
        din_valid = 1'b0;
        wait_idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
